// File: rtl/wave_display_reader.sv
// wave_display_reader
//   Read side of the waveform scope. Scans one half of the 512-entry sample
//   RAM (256 x 8-bit offset-binary samples) and turns each pixel coordinate
//   from the video timing generator into a lit or unlit trace pixel. It also
//   flags when it is idle, so the capture side can swap RAM halves between
//   frames without tearing.
//
//   Optional feature: define WAVE_DISPLAY_GRID_EN to draw a grid (zero line
//   plus vertical divisions every 64 columns) in GRID_COLOR behind the trace.
//
// Ports
//   clk               system clock
//   reset             asynchronous reset, active low
//   valid, x, y       pixel coordinate from the timing generator
//   read_index        RAM half holding the most recently completed capture
//   read_address      RAM address, combinational from x and the latched half
//   read_value        RAM data, returned one cycle after read_address
//   valid_pixel,r,g,b pixel output, two cycles after valid/x/y
//   wave_display_idle high while the RAM contents are not being used
module wave_display_reader #(
  parameter logic [10:0] X_START    = 11'd256,
  parameter logic [23:0] WAVE_COLOR = 24'hFFFFFF,
  parameter logic [23:0] GRID_COLOR = 24'h404040
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        read_index,
  input  logic [7:0]  read_value,
  output logic [8:0]  read_address,
  output logic        valid_pixel,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        wave_display_idle
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        frame_load;
  logic        frame_index;

  // ---------------- window / address (stage 0, combinational) -------------
  logic [10:0] xo;
  logic        in_win;

  // The x >= X_START term keeps columns left of the window from wrapping
  // into range through the subtraction.
  assign xo           = x - X_START;
  assign in_win       = valid && (x >= X_START) && (xo[10:9] == 2'b00) && !y[9];
  assign read_address = {frame_index, xo[8:1]};   // two columns per sample

  // ---------------- frame FSM ----------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid && (y == 10'd0) && (x == 11'd0)) state_nxt = SCAN;
      SCAN:    if (valid && y[9])                         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The RAM half is latched only at the frame origin, so a capture that
  // completes mid-frame is shown from the next frame on.
  always_comb begin
    frame_load = (state == IDLE) && (state_nxt == SCAN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_index       <= 1'b0;
      wave_display_idle <= 1'b1;
    end else begin
      if (frame_load) frame_index <= read_index;
      wave_display_idle <= (state_nxt == IDLE);
    end
  end

  // ---------------- stage 1: RAM data arrives ------------------------------
  logic [1:0] vld_pipe;
  logic       s1_win, s1_scan;
  logic [7:0] s1_row;
  logic [8:0] s1_col;
  logic [7:0] prev_sample;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= 2'b00;
      s1_win   <= 1'b0;
      s1_scan  <= 1'b0;
      s1_row   <= 8'd0;
      s1_col   <= 9'd0;
    end else begin
      vld_pipe <= {vld_pipe[0], valid};
      s1_win   <= in_win;
      s1_scan  <= (state == SCAN);
      s1_row   <= y[8:1];
      s1_col   <= xo[8:0];
    end
  end

  // Captured on the second column of each sample, so both columns of the
  // following sample draw a connector back to this one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   prev_sample <= 8'h80;
    else if (s1_win && s1_col[0]) prev_sample <= read_value;
  end

  // Samples are flipped so full scale sits at the top of the window.
  logic [7:0]  cur, prv, lo, hi;
  logic        lit, grid;
  logic [23:0] px_color;

  always_comb begin
    cur = ~read_value;
    // Column 0 starts a fresh line: no connector from the previous row's end.
    prv = (s1_col == 9'd0) ? cur : ~prev_sample;
    lo  = (cur < prv) ? cur : prv;
    hi  = (cur < prv) ? prv : cur;
    lit = s1_win && s1_scan && (s1_row >= lo) && (s1_row <= hi);
  end

`ifdef WAVE_DISPLAY_GRID_EN
  logic unused_ok;
  assign grid      = s1_win && s1_scan && ((s1_row == 8'h7F) || (s1_col[5:0] == 6'd0));
  assign unused_ok = y[0];
`else
  logic unused_ok;
  assign grid      = 1'b0;
  assign unused_ok = ^{y[0], GRID_COLOR};
`endif

  // Trace wins over grid.
  assign px_color = lit ? WAVE_COLOR : (grid ? GRID_COLOR : 24'h000000);

  // ---------------- stage 2: registered outputs ----------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) {r, g, b} <= 24'h000000;
    else        {r, g, b} <= px_color;
  end

  assign valid_pixel = vld_pipe[1];

endmodule

// File: tb/tb_wave_display_reader.sv
// tb_wave_display_reader
//   Self-checking bench for wave_display_reader. A behavioural RAM answers
//   read_address one cycle later. Every driven pixel pushes its expected
//   output into a scoreboard queue tagged with the cycle it is due; entries
//   are popped and compared when that cycle comes round.
module tb_wave_display_reader;

  localparam logic [10:0] XS   = 11'd256;
  localparam logic [23:0] WAVE = 24'hFFFFFF;
  localparam logic [23:0] GRID = 24'h404040;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [10:0] x;
  logic [9:0]  y;
  logic        read_index;
  logic [7:0]  read_value;
  logic [8:0]  read_address;
  logic        valid_pixel;
  logic [7:0]  r, g, b;
  logic        wave_display_idle;

  wave_display_reader #(.X_START(XS), .WAVE_COLOR(WAVE), .GRID_COLOR(GRID)) dut (
    .clk(clk), .reset(reset), .valid(valid), .x(x), .y(y),
    .read_index(read_index), .read_value(read_value), .read_address(read_address),
    .valid_pixel(valid_pixel), .r(r), .g(g), .b(b),
    .wave_display_idle(wave_display_idle)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:511];
  always @(posedge clk) read_value <= ram[read_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        vp;
    logic [23:0] rgb;
    logic [10:0] px;
    logic [9:0]  py;
  } exp_t;
  exp_t q[$];

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic       m_scan;
  logic       m_frame;
  logic [7:0] m_prev;

  task automatic model_reset();
    m_scan  = 1'b0;
    m_frame = 1'b0;
    m_prev  = 8'h80;
  endtask

  // One pixel per cycle: checks due outputs, drives, predicts.
  task automatic drive(input logic v, input logic [10:0] xx, input logic [9:0] yy);
    logic [10:0] xo;
    logic        win;
    logic [8:0]  addr;
    logic [7:0]  s, cur, prv, row;
    logic        lit_c;
    logic [23:0] c;
    exp_t        e;
    @(negedge clk);
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      n_chk++;
      if (valid_pixel !== e.vp || {r, g, b} !== e.rgb) begin
        n_fail++;
        $display("FAIL pixel x=%0d y=%0d: got vp=%b rgb=%h, want vp=%b rgb=%h",
                 e.px, e.py, valid_pixel, {r, g, b}, e.vp, e.rgb);
      end
    end
    n_chk++;
    if (wave_display_idle !== !m_scan) begin
      n_fail++;
      $display("FAIL idle before x=%0d y=%0d: got %b want %b", xx, yy, wave_display_idle, !m_scan);
    end
    valid = v; x = xx; y = yy;
    #1;
    xo   = xx - XS;
    win  = v && (xx >= XS) && (xo < 11'd512) && (yy < 10'd512);
    addr = {m_frame, xo[8:1]};
    if (win) begin
      n_chk++;
      if (read_address !== addr) begin
        n_fail++;
        $display("FAIL read_address x=%0d y=%0d: got %h want %h", xx, yy, read_address, addr);
      end
    end
    s     = ram[addr];
    row   = yy[8:1];
    cur   = 8'hFF - s;
    prv   = (xo[8:0] == 9'd0) ? cur : 8'hFF - m_prev;
    lit_c = win && m_scan && ((row >= cur && row <= prv) || (row >= prv && row <= cur));
    c     = lit_c ? WAVE : 24'h0;
`ifdef WAVE_DISPLAY_GRID_EN
    if (!lit_c && win && m_scan && (row == 8'h7F || xo[5:0] == 6'd0)) c = GRID;
`endif
    e.due = cyc + 2; e.vp = v; e.rgb = c; e.px = xx; e.py = yy;
    q.push_back(e);
    if (win && xo[0]) m_prev = s;
    if (!m_scan && v && yy == 10'd0 && xx == 11'd0) begin
      m_scan  = 1'b1;
      m_frame = read_index;
    end else if (m_scan && v && yy[9]) begin
      m_scan = 1'b0;
    end
  endtask

  task automatic drain();
    repeat (3) drive(1'b0, 11'd0, 10'd300);
  endtask

  task automatic drive_row(input logic [9:0] yy, input int x0, input int x1);
    for (int i = x0; i <= x1; i++) drive(1'b1, 11'(i), yy);
  endtask

  task automatic fill_half(input logic h, input logic [7:0] v);
    for (int i = 0; i < 256; i++) ram[{h, 8'(i)}] = v;
  endtask

  task automatic fill_rand(input logic h);
    for (int i = 0; i < 256; i++) ram[{h, 8'(i)}] = 8'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b0; valid = 1'b0; x = '0; y = '0; read_index = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (valid_pixel !== 1'b0 || {r, g, b} !== 24'h0 || wave_display_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got vp=%b rgb=%h idle=%b want 0/000000/1",
               valid_pixel, {r, g, b}, wave_display_idle);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_frame_start();
    fill_half(1'b1, 8'h80);
    read_index = 1'b1;
    drive(1'b1, 11'd0, 10'd0);
    drive(1'b1, 11'd300, 10'd0);
    n_chk++;
    if (read_address !== 9'h116) begin
      n_fail++;
      $display("FAIL frame_start_addr: got %h want 116", read_address);
    end
    drive_row(10'd0, 301, 310);
  endtask

  // flat mid-scale: only row 127 (y 254/255) lit across the window
  task automatic test_flat();
    for (int yy = 250; yy <= 257; yy++) drive_row(10'(yy), 255, 768);
    drive(1'b1, 11'd0, 10'd512);
    @(posedge clk); #1;
    n_chk++;
    if (wave_display_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_rise: got %b want 1", wave_display_idle);
    end
    drain();
  endtask

  task automatic test_connector();
    fill_half(1'b0, 8'h80);
    ram[0] = 8'h00;
    ram[1] = 8'hFF;
    read_index = 1'b0;
    drive(1'b1, 11'd0, 10'd0);
    for (int yy = 0; yy < 512; yy++) drive_row(10'(yy), 256, 259);
    drive(1'b1, 11'd0, 10'd512);
    drain();
  endtask

  task automatic test_index_toggle();
    read_index = 1'b0;
    drive(1'b1, 11'd0, 10'd0);
    drive_row(10'd10, 256, 260);
    read_index = 1'b1;
    drive(1'b1, 11'd300, 10'd10);
    n_chk++;
    if (read_address[8] !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_addr_msb: got %b want 0", read_address[8]);
    end
    drive_row(10'd11, 256, 300);
    drive(1'b1, 11'd0, 10'd511);
    @(posedge clk); #1;
    n_chk++;
    if (wave_display_idle !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_row511: got %b want 0", wave_display_idle);
    end
    drive(1'b1, 11'd0, 10'd512);
    drive(1'b1, 11'd5, 10'd520);
    drive(1'b1, 11'd0, 10'd0);
    @(posedge clk); #1;
    n_chk++;
    if (wave_display_idle !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_fall: got %b want 0", wave_display_idle);
    end
    drive(1'b1, 11'd300, 10'd0);
    n_chk++;
    if (read_address !== 9'h116) begin
      n_fail++;
      $display("FAIL toggle_next_frame_addr: got %h want 116", read_address);
    end
    drive(1'b1, 11'd0, 10'd512);
    drain();
  endtask

  task automatic test_valid_low();
    fill_rand(1'b1);
    read_index = 1'b1;
    drive(1'b1, 11'd0, 10'd0);
    for (int yy = 100; yy <= 103; yy++)
      for (int xx = 256; xx <= 767; xx++)
        drive(($urandom % 4) != 0, 11'(xx), 10'(yy));
    drive(1'b0, 11'd0, 10'd512);   // not valid: must stay scanning
    drive(1'b0, 11'd0, 10'd0);
    drive(1'b1, 11'd0, 10'd512);
    drain();
  endtask

  task automatic test_reset_mid();
    fill_half(1'b0, 8'h80);
    read_index = 1'b1;
    fill_half(1'b1, 8'h80);
    drive(1'b1, 11'd0, 10'd0);
    drive_row(10'd254, 256, 300);
    @(negedge clk);
    reset = 1'b0; valid = 1'b0;
    q.delete();
    #1;
    n_chk++;
    if (valid_pixel !== 1'b0 || {r, g, b} !== 24'h0 || wave_display_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got vp=%b rgb=%h idle=%b want 0/000000/1",
               valid_pixel, {r, g, b}, wave_display_idle);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    drive_row(10'd254, 250, 770);   // IDLE after reset: black
    drive(1'b1, 11'd0, 10'd0);
    drive_row(10'd254, 250, 770);
    drive(1'b1, 11'd0, 10'd512);
    drain();
  endtask

  task automatic test_back_to_back();
    fill_rand(1'b0);
    fill_rand(1'b1);
    for (int f = 0; f < 2; f++) begin
      read_index = f[0];
      drive(1'b1, 11'd0, 10'd0);
      for (int k = 0; k < 3; k++) drive_row(10'($urandom_range(0, 511)), 254, 770);
      drive(1'b1, 11'd0, 10'd512);
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 8'h80;
    model_reset();
    test_reset();
    test_frame_start();
    test_flat();
    test_connector();
    test_index_toggle();
    test_valid_low();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
